// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder with valid/ready handshakes
// One full-adder slice (two half adders) is reused LSB-first over WIDTH cycles.

module halfadder (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);
  assign sum   = x ^ y;
  assign carry = x & y;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;

  logic             w_ha1_sum;
  logic             w_ha1_carry;
  logic             w_bit_sum;
  logic             w_ha2_carry;
  logic             w_carry_next;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_next;

  halfadder u_ha1 (
    .x     (r_a_sh[0]),
    .y     (r_b_sh[0]),
    .sum   (w_ha1_sum),
    .carry (w_ha1_carry)
  );

  halfadder u_ha2 (
    .x     (w_ha1_sum),
    .y     (r_c),
    .sum   (w_bit_sum),
    .carry (w_ha2_carry)
  );

  assign w_carry_next = w_ha1_carry | w_ha2_carry;
  assign w_last       = (r_cnt == CW'(WIDTH - 1));

  // A 1-bit result has no older bits to shift in.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_sum_next = w_bit_sum;
    end else begin : g_wn
      assign w_sum_next = {w_bit_sum, r_sum_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum_sh    <= '0;
      r_c         <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_c    <= cin;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_sum_sh <= w_sum_next;
          r_c      <= w_carry_next;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum       <= w_sum_next;
            r_cout      <= w_carry_next;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl
// Covers WIDTH=8 vectors and backpressure, mid-run reset, WIDTH=1 latency, WIDTH=4 exhaustive.

module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv8, ir8, ov8, or8, cin8, cout8, busy8;
  logic [7:0] a8, b8, s8;
  logic       iv1, ir1, ov1, or1, cin1, cout1, busy1;
  logic [0:0] a1, b1, s1;
  logic       iv4, ir4, ov4, or4, cin4, cout4, busy4;
  logic [3:0] a4, b4, s4;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(cout8), .busy(busy8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(cout1), .busy(busy1)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(cout4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec);
    int   lat;
    logic seen_ready;
    @(negedge clk);
    check("in_ready_idle8", ir8, 1);
    a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
    lat = 0;
    seen_ready = 1'b0;
    while (!ov8 && lat < 40) begin
      if (ir8) seen_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("latency8", lat, 8);
    check("in_ready_low_run8", seen_ready, 0);
    check("sum8", s8, es);
    check("cout8", cout8, ec);
    check("busy_done8", busy8, 1);
    check("in_ready_done8", ir8, 0);
  endtask

  task automatic release8();
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    check("ov_clear8", ov8, 0);
    check("in_ready_back8", ir8, 1);
    check("busy_idle8", busy8, 0);
  endtask

  logic [4:0] exp_q[$];
  int         n_got  = 0;
  logic       mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && ov4) begin
      if (exp_q.size() == 0) begin
        check("exh_extra_result", 1, 0);
      end else begin
        check("exh4", {cout4, s4}, exp_q.pop_front());
      end
      n_got++;
    end
  end

  initial begin
    int   lat;
    int   guard;
    logic seen;

    rst = 1'b1;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    iv1 = 0; or1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    iv4 = 0; or4 = 1; a4 = 0; b4 = 0; cin4 = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", ir8, 1);
    check("rst_out_valid", ov8, 0);
    check("rst_busy", busy8, 0);
    check("rst_sum", s8, 0);
    check("rst_cout", cout8, 0);

    run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    release8();
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    release8();
    run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    release8();
    run8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);

    // Backpressure: new operands offered in DONE must be ignored.
    for (int i = 0; i < 5; i++) begin
      a8 = 8'h11 * 8'(i + 1); b8 = 8'h22; cin8 = 1'b1; iv8 = 1'b1;
      @(negedge clk);
      check("bp_out_valid", ov8, 1);
      check("bp_sum", s8, 8'h7E);
      check("bp_cout", cout8, 0);
    end
    iv8 = 1'b0;
    release8();
    @(negedge clk);
    check("hold_sum_idle", s8, 8'h7E);
    check("hold_idle_no_accept", busy8, 0);

    // Reset after three RUN edges.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy8, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", ir8, 1);
    check("mid_rst_out_valid", ov8, 0);
    check("mid_rst_sum", s8, 0);
    check("mid_rst_cout", cout8, 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ov8) seen = 1'b1;
    end
    check("mid_rst_no_result", seen, 0);

    // WIDTH=1 latency.
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency1", lat, 1);
    check("sum1", s1, 1);
    check("cout1", cout1, 1);
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
    check("ov_clear1", ov1, 0);

    // WIDTH=4 exhaustive, in_valid held high, out_ready tied high.
    mon_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8]; iv4 = 1'b1;
      guard = 0;
      while (!ir4 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) check("exh_accept_timeout", 0, 1);
      exp_q.push_back(5'(i[3:0] + i[7:4] + i[8]));
      @(negedge clk);
    end
    iv4 = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("exh_count", n_got, 512);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
